// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer and the serial pattern detector it feeds.
// The idle level lives here so both blocks agree on what an empty line looks like.
package word_serializer_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and emits one bit
// per clock on a registered line, streaming consecutive words with no gap.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             frame_start
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic [WIDTH-1:0] w_shifted;
  logic             r_data, w_data_d;
  logic             r_data_valid, w_data_valid_d;
  logic             r_frame_start, w_frame_start_d;
  logic             w_last;
  logic             w_accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  // Ready on the last bit lets the next word follow without a bubble.
  assign w_last    = (r_state == StShift) && (r_cnt == CntLast);
  assign in_ready  = rst && ((r_state == StIdle) || w_last);
  assign w_accept  = in_valid && in_ready;
  assign w_shifted = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_data        <= IDLE_BIT;
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_shift       <= w_shift_d;
      r_data        <= w_data_d;
      r_data_valid  <= w_data_valid_d;
      r_frame_start <= w_frame_start_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StShift;
      StShift: if (w_last && !w_accept) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d         = r_cnt;
    w_shift_d       = r_shift;
    w_data_d        = IDLE_BIT;
    w_data_valid_d  = 1'b0;
    w_frame_start_d = 1'b0;
    if (w_accept) begin
      w_shift_d       = in_data;
      w_cnt_d         = '0;
      w_data_d        = first_bit(in_data);
      w_data_valid_d  = 1'b1;
      w_frame_start_d = 1'b1;
    end else if ((r_state == StShift) && !w_last) begin
      w_shift_d      = w_shifted;
      w_cnt_d        = r_cnt + 1'b1;
      w_data_d       = first_bit(w_shifted);
      w_data_valid_d = 1'b1;
    end else begin
      w_cnt_d = '0;
    end
  end

  assign data        = r_data;
  assign data_valid  = r_data_valid;
  assign frame_start = r_frame_start;

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial front end for the serial pattern detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial line, which drives the detector's `data` input directly. Consecutive words stream with no idle bit between them. When no word is in flight, the line holds a fixed idle level, so the detector never sees spurious bits.

## Interface
- `WIDTH`, 8: bits per word; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, 1'b0: level driven on `data` when no word is in flight.

- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset; low = in reset.
- `in_data`  input  WIDTH  word to serialize; sampled only on an accept edge.
- `in_valid`  input  1  upstream has a word on `in_data`.
- `in_ready`  output  1  block can accept a word this cycle.
- `data`  output  1  registered serial bit to the detector.
- `data_valid`  output  1  `data` carries a word bit this cycle.
- `frame_start`  output  1  one-cycle pulse on the first bit of each word.

## Operation
- State machine with two states:
  - IDLE: no word in flight.
  - SHIFT: word in flight.
- Internal state:
  - shift register, WIDTH bits;
  - bit counter `cnt`, width $clog2(WIDTH), counting 0..WIDTH-1.
- Reset (rst = 0), asynchronous:
  - state = IDLE, `cnt` = 0, shift register = 0;
  - `data` = IDLE_BIT, `data_valid` = 0, `frame_start` = 0;
  - `in_ready` = 0 while rst is low.
- `in_ready` is combinational: rst high AND (state == IDLE OR (state == SHIFT AND `cnt` == WIDTH-1)).
- Accept = `in_valid` & `in_ready` at a rising edge. On accept:
  - load `in_data` into the shift register;
  - first bit goes to `data`;
  - `data_valid` = 1, `frame_start` = 1, `cnt` = 0;
  - state = SHIFT.
- SHIFT with `cnt` < WIDTH-1:
  - shift toward the output end (MSB-first shifts left, LSB-first shifts right);
  - next bit goes to `data`, `cnt` increments;
  - `frame_start` = 0.
- SHIFT with `cnt` == WIDTH-1:
  - on accept, reload as above; no bubble between words;
  - otherwise state = IDLE, `data` = IDLE_BIT, `data_valid` = 0.
- Each word occupies exactly WIDTH consecutive `data_valid` cycles. Words are never truncated or reordered.
- `in_data` and `in_valid` are ignored while `in_ready` = 0. Upstream holds them until accepted.
- `in_valid` = 1 on the same edge that rst goes high: no accept. The first possible accept is the following edge.
- Reset mid-word: the partial word is discarded and not resumed. The line returns to IDLE_BIT immediately, asynchronously.

## Timing
- Latency: accept at edge N puts the first bit on `data` after edge N, valid during cycle N+1. The last bit is valid during cycle N+WIDTH.
- Cycle N+WIDTH+1: either the next word's first bit (if accepted at edge N+WIDTH) or IDLE_BIT with `data_valid` = 0.
- `frame_start` is high only in the first-bit cycle of each word, including back-to-back words.
- All outputs except `in_ready` are registered. `in_ready` has no combinational path from `in_valid`.
- Sustained throughput: one word per WIDTH cycles.

## Structure
- Shared package contents:
  - state enum (IDLE, SHIFT);
  - default IDLE_BIT constant, shared with the detector so both use the same idle level.
- Single module; no sub-module warranted. The shift register and counter stay inline.

## Test plan
All scenarios use WIDTH = 8, MSB_FIRST = 1, IDLE_BIT = 0 unless noted.

- Reset:
  - hold rst = 0 → `data` = 0, `data_valid` = 0, `frame_start` = 0, `in_ready` = 0;
  - release → `in_ready` = 1 the same cycle; no accept on the release edge.
- Single word `in_data` = 8'hE0, accepted at edge 0:
  - cycles 1–8: `data` = 1,1,1,0,0,0,0,0;
  - `frame_start` high in cycle 1 only;
  - `data_valid` = 1 in cycles 1–8 and 0 in cycle 9;
  - `in_ready` = 0 in cycles 1–7 and 1 in cycle 8;
  - a downstream detector pulses its output in cycle 4.
- Back-to-back 8'hA5 then 8'h3C, `in_valid` held high:
  - 16 contiguous valid bits 10100101 00111100;
  - `frame_start` in cycles 1 and 9 only; no idle cycle between words.
- MSB_FIRST = 0, word 8'h01 → bits 1,0,0,0,0,0,0,0.
- Backpressure:
  - `in_valid` = 1 during cycle 3 of an in-flight word, with `in_data` changing each cycle;
  - no accept until `cnt` == 7;
  - the word serialized next is the `in_data` value present at that edge.
- Reset mid-word:
  - assert rst = 0 after 3 bits of 8'hFF → `data` = 0 and `data_valid` = 0 immediately;
  - after release, the block is in IDLE with `in_ready` = 1, and the remaining 5 bits are never sent.
